// File: rtl/game_pkg.sv
// Shared game constants: top-level game states, monster FSM encoding and sprite sizes.
package game_pkg;

    localparam int unsigned POS_W = 10;
    localparam int unsigned SUM_W = POS_W + 1;
    localparam int unsigned HIT_W = 8;

    localparam logic [1:0] PLAY_STATE = 2'd2;
    localparam logic [1:0] MENU_STATE = 2'd0;

    localparam int unsigned BUL_W_DEF = 10;
    localparam int unsigned BUL_H_DEF = 11;
    localparam int unsigned MON_W_DEF = 60;
    localparam int unsigned MON_H_DEF = 60;
    localparam int unsigned PLY_W_DEF = 60;
    localparam int unsigned PLY_H_DEF = 60;
    localparam int unsigned FLASH_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_ARMED = 2'd1,
        MON_FLASH = 2'd2,
        MON_DEAD  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test between box A and box B; sums widened so edges near 1023 never wrap.
module aabb_overlap
    import game_pkg::*;
#(
    parameter int unsigned A_W = 10,
    parameter int unsigned A_H = 11,
    parameter int unsigned B_W = 60,
    parameter int unsigned B_H = 60
) (
    input  logic [POS_W-1:0] a_x_i,
    input  logic [POS_W-1:0] a_y_i,
    input  logic [POS_W-1:0] b_x_i,
    input  logic [POS_W-1:0] b_y_i,
    output logic             overlap_c
);

    logic [SUM_W-1:0] a_x_ext, a_y_ext, b_x_ext, b_y_ext;
    logic [SUM_W-1:0] a_r, a_b, b_r, b_b;

    assign a_x_ext = SUM_W'(a_x_i);
    assign a_y_ext = SUM_W'(a_y_i);
    assign b_x_ext = SUM_W'(b_x_i);
    assign b_y_ext = SUM_W'(b_y_i);

    assign a_r = a_x_ext + SUM_W'(A_W);
    assign a_b = a_y_ext + SUM_W'(A_H);
    assign b_r = b_x_ext + SUM_W'(B_W);
    assign b_b = b_y_ext + SUM_W'(B_H);

    // Strict compares: touching edges do not count as overlap.
    assign overlap_c = (a_x_ext < b_r) && (b_x_ext < a_r) &&
                       (a_y_ext < b_b) && (b_y_ext < a_b);

endmodule

// File: rtl/monster_hit_ctrl.sv
// Monster life-cycle FSM with bullet/player collision detection, flash delay, kill/score/death pulses.
module monster_hit_ctrl
    import game_pkg::*;
#(
    parameter int unsigned BUL_W        = BUL_W_DEF,
    parameter int unsigned BUL_H        = BUL_H_DEF,
    parameter int unsigned MON_W        = MON_W_DEF,
    parameter int unsigned MON_H        = MON_H_DEF,
    parameter int unsigned PLY_W        = PLY_W_DEF,
    parameter int unsigned PLY_H        = PLY_H_DEF,
    parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state,
    input  logic             bul_exist,
    input  logic [POS_W-1:0] bul_x,
    input  logic [POS_W-1:0] bul_y,
    input  logic             mon_active,
    input  logic [POS_W-1:0] mon_x,
    input  logic [POS_W-1:0] mon_y,
    input  logic [POS_W-1:0] plyr_x,
    input  logic [POS_W-1:0] plyr_y,
    output logic [1:0]       mon_state,
    output logic             bullet_kill,
    output logic             mon_kill,
    output logic             score_add,
    output logic             plyr_dead,
    output logic [HIT_W-1:0] hit_count
);

    localparam int unsigned CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    mon_state_e       mon_state_q, mon_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HIT_W-1:0] hit_q, hit_d;
    logic             bullet_kill_q, bullet_kill_d;
    logic             mon_kill_q, mon_kill_d;
    logic             plyr_dead_q, plyr_dead_d;
    logic             bul_ovl_c, ply_ovl_c, bul_hit_c;

    aabb_overlap #(.A_W(BUL_W), .A_H(BUL_H), .B_W(MON_W), .B_H(MON_H)) u_bul_ovl (
        .a_x_i     (bul_x),
        .a_y_i     (bul_y),
        .b_x_i     (mon_x),
        .b_y_i     (mon_y),
        .overlap_c (bul_ovl_c)
    );

    aabb_overlap #(.A_W(PLY_W), .A_H(PLY_H), .B_W(MON_W), .B_H(MON_H)) u_ply_ovl (
        .a_x_i     (plyr_x),
        .a_y_i     (plyr_y),
        .b_x_i     (mon_x),
        .b_y_i     (mon_y),
        .overlap_c (ply_ovl_c)
    );

    assign bul_hit_c = bul_exist & bul_ovl_c;

    // Next-state logic; leaving PLAYING parks the monster and only MENU wipes the score.
    always_comb begin
        mon_state_d   = mon_state_q;
        cnt_d         = cnt_q;
        hit_d         = hit_q;
        bullet_kill_d = 1'b0;
        mon_kill_d    = 1'b0;
        plyr_dead_d   = 1'b0;

        if (state != PLAY_STATE) begin
            mon_state_d = MON_IDLE;
            cnt_d       = '0;
            if (state == MENU_STATE) begin
                hit_d = '0;
            end
        end else begin
            case (mon_state_q)
                MON_IDLE: begin
                    if (mon_active) begin
                        mon_state_d = MON_ARMED;
                    end
                end
                MON_ARMED: begin
                    if (!mon_active) begin
                        mon_state_d = MON_IDLE;
                    end else if (bul_hit_c) begin
                        mon_state_d   = MON_FLASH;
                        bullet_kill_d = 1'b1;
                        cnt_d         = CNT_W'(FLASH_CYCLES - 1);
                    end else if (ply_ovl_c) begin
                        mon_state_d = MON_DEAD;
                        plyr_dead_d = 1'b1;
                    end
                end
                MON_FLASH: begin
                    if (!mon_active) begin
                        mon_state_d = MON_IDLE;
                        cnt_d       = '0;
                    end else if (cnt_q == '0) begin
                        mon_state_d = MON_DEAD;
                        mon_kill_d  = 1'b1;
                        if (hit_q != {HIT_W{1'b1}}) begin
                            hit_d = hit_q + HIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MON_DEAD: begin
                    if (!mon_active) begin
                        mon_state_d = MON_IDLE;
                    end
                end
                default: mon_state_d = MON_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_state_q   <= MON_IDLE;
            cnt_q         <= '0;
            hit_q         <= '0;
            bullet_kill_q <= 1'b0;
            mon_kill_q    <= 1'b0;
            plyr_dead_q   <= 1'b0;
        end else begin
            mon_state_q   <= mon_state_d;
            cnt_q         <= cnt_d;
            hit_q         <= hit_d;
            bullet_kill_q <= bullet_kill_d;
            mon_kill_q    <= mon_kill_d;
            plyr_dead_q   <= plyr_dead_d;
        end
    end

    assign mon_state   = mon_state_q;
    assign bullet_kill = bullet_kill_q;
    assign mon_kill    = mon_kill_q;
    assign score_add   = mon_kill_q;
    assign plyr_dead   = plyr_dead_q;
    assign hit_count   = hit_q;

endmodule

// File: tb/tb_monster_hit_ctrl.sv
// Scoreboard bench for monster_hit_ctrl: a cycle model queues expected outputs, popped after each edge.
module tb_monster_hit_ctrl;

    localparam int FLASH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic       bul_exist;
    logic [9:0] bul_x, bul_y;
    logic       mon_active;
    logic [9:0] mon_x, mon_y;
    logic [9:0] plyr_x, plyr_y;
    logic [1:0] mon_state;
    logic       bullet_kill, mon_kill, score_add, plyr_dead;
    logic [7:0] hit_count;

    typedef struct {
        logic [1:0] st;
        logic       bk;
        logic       mk;
        logic       pd;
        logic [7:0] hc;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   m_st = 0, m_cnt = 0, m_hit = 0;
    int   flash_seen = 0, mk_seen = 0, bk_seen = 0, pd_seen = 0;

    monster_hit_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .bul_exist   (bul_exist),
        .bul_x       (bul_x),
        .bul_y       (bul_y),
        .mon_active  (mon_active),
        .mon_x       (mon_x),
        .mon_y       (mon_y),
        .plyr_x      (plyr_x),
        .plyr_y      (plyr_y),
        .mon_state   (mon_state),
        .bullet_kill (bullet_kill),
        .mon_kill    (mon_kill),
        .score_add   (score_add),
        .plyr_dead   (plyr_dead),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ovl(input int ax, ay, aw, ah, bx, by, bw, bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    // One clock: predict from current inputs, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        bit   bh, ph;
        e.bk = 1'b0; e.mk = 1'b0; e.pd = 1'b0;
        bh = bul_exist && ovl(int'(bul_x), int'(bul_y), 10, 11, int'(mon_x), int'(mon_y), 60, 60);
        ph = ovl(int'(plyr_x), int'(plyr_y), 60, 60, int'(mon_x), int'(mon_y), 60, 60);
        if (rst) begin
            m_st = 0; m_cnt = 0; m_hit = 0;
        end else if (state != 2'd2) begin
            m_st = 0; m_cnt = 0;
            if (state == 2'd0) m_hit = 0;
        end else begin
            if (m_st == 0) begin
                if (mon_active) m_st = 1;
            end else if (m_st == 1) begin
                if (!mon_active) m_st = 0;
                else if (bh) begin m_st = 2; e.bk = 1'b1; m_cnt = FLASH - 1; end
                else if (ph) begin m_st = 3; e.pd = 1'b1; end
            end else if (m_st == 2) begin
                if (!mon_active) begin m_st = 0; m_cnt = 0; end
                else if (m_cnt == 0) begin
                    m_st = 3; e.mk = 1'b1;
                    if (m_hit < 255) m_hit++;
                end else m_cnt--;
            end else begin
                if (!mon_active) m_st = 0;
            end
        end
        e.st = 2'(m_st);
        e.hc = 8'(m_hit);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("mon_state", 32'(mon_state), 32'(e.st));
        chk("bullet_kill", 32'(bullet_kill), 32'(e.bk));
        chk("mon_kill", 32'(mon_kill), 32'(e.mk));
        chk("score_add", 32'(score_add), 32'(e.mk));
        chk("plyr_dead", 32'(plyr_dead), 32'(e.pd));
        chk("hit_count", 32'(hit_count), 32'(e.hc));
        if (mon_state == 2'd2) flash_seen++;
        if (mon_kill) mk_seen++;
        if (bullet_kill) bk_seen++;
        if (plyr_dead) pd_seen++;
    endtask

    // Arm a monster, fire one bullet at bx,by and report whether bullet_kill rose.
    task automatic try_hit(input logic [9:0] mx, input logic [9:0] bx, input logic [9:0] by,
                           input bit exp_hit, input string tag);
        mon_x = mx; mon_y = 10'd100;
        mon_active = 1'b1; bul_exist = 1'b0;
        step();
        bul_x = bx; bul_y = by; bul_exist = 1'b1;
        step();
        chk(tag, 32'(bullet_kill), 32'(exp_hit));
        bul_exist = 1'b0; mon_active = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; state = 2'd0; bul_exist = 1'b0; bul_x = '0; bul_y = '0;
        mon_active = 1'b0; mon_x = 10'd200; mon_y = 10'd100;
        plyr_x = 10'd600; plyr_y = 10'd400;

        // Reset
        step(); step();
        chk("reset_state", 32'(mon_state), 32'd0);
        chk("reset_hits", 32'(hit_count), 32'd0);

        // Basic kill with flash delay
        rst = 1'b0; state = 2'd2; mon_active = 1'b1;
        step();
        chk("armed", 32'(mon_state), 32'd1);
        bul_exist = 1'b1; bul_x = 10'd230; bul_y = 10'd130;
        flash_seen = 0; mk_seen = 0; bk_seen = 0;
        step();
        bul_exist = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("flash_cycles", 32'(flash_seen), 32'd8);
        chk("kill_pulses", 32'(mk_seen), 32'd1);
        chk("bk_pulses", 32'(bk_seen), 32'd1);
        chk("dead_state", 32'(mon_state), 32'd3);
        chk("one_kill", 32'(hit_count), 32'd1);
        mon_active = 1'b0;
        step();

        // Overlap edges, including a bullet near the right screen edge
        try_hit(10'd200, 10'd190, 10'd130, 1'b0, "edge_x190");
        try_hit(10'd200, 10'd260, 10'd130, 1'b0, "edge_x260");
        try_hit(10'd200, 10'd191, 10'd130, 1'b1, "edge_x191");
        try_hit(10'd200, 10'd259, 10'd130, 1'b1, "edge_x259");
        try_hit(10'd200, 10'd230, 10'd89,  1'b0, "edge_y89");
        try_hit(10'd200, 10'd230, 10'd90,  1'b1, "edge_y90");
        try_hit(10'd1000, 10'd1023, 10'd130, 1'b1, "edge_wrap");
        mon_x = 10'd200;

        // Bullet and player together: bullet wins
        mon_active = 1'b1;
        step();
        plyr_x = 10'd220; plyr_y = 10'd120;
        bul_exist = 1'b1; bul_x = 10'd230; bul_y = 10'd130;
        step();
        chk("both_bk", 32'(bullet_kill), 32'd1);
        chk("both_pd", 32'(plyr_dead), 32'd0);
        chk("both_flash", 32'(mon_state), 32'd2);
        bul_exist = 1'b0; mon_active = 1'b0;
        step();

        // Player touches live monster
        mon_active = 1'b1;
        step();
        pd_seen = 0;
        step(); step(); step();
        chk("pd_pulses", 32'(pd_seen), 32'd1);
        chk("pd_dead", 32'(mon_state), 32'd3);
        mon_active = 1'b0; plyr_x = 10'd600; plyr_y = 10'd400;
        step();
        chk("pd_idle", 32'(mon_state), 32'd0);

        // Leave PLAYING on 3rd flash cycle: no kill
        mon_active = 1'b1;
        step();
        bul_exist = 1'b1;
        step();
        bul_exist = 1'b0;
        step(); step();
        mk_seen = 0;
        state = 2'd1;
        step();
        chk("abort_idle", 32'(mon_state), 32'd0);
        step();
        chk("abort_nokill", 32'(mk_seen), 32'd0);
        chk("abort_hits", 32'(hit_count), 32'd1);
        state = 2'd2;
        mon_active = 1'b0;
        step();

        // Reset in the middle of FLASH: no kill
        mon_active = 1'b1;
        step();
        bul_exist = 1'b1;
        step();
        bul_exist = 1'b0;
        step();
        mk_seen = 0;
        rst = 1'b1;
        step();
        rst = 1'b0; mon_active = 1'b0;
        step();
        chk("rst_flash_nokill", 32'(mk_seen), 32'd0);
        chk("rst_flash_idle", 32'(mon_state), 32'd0);

        // Saturation: 256 kills
        for (int k = 0; k < 256; k++) begin
            mon_active = 1'b1;
            step();
            bul_exist = 1'b1;
            step();
            bul_exist = 1'b0;
            for (int j = 0; j < FLASH; j++) step();
            mon_active = 1'b0;
            step();
        end
        chk("saturated", 32'(hit_count), 32'd255);
        state = 2'd0;
        step();
        chk("menu_clear", 32'(hit_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
